// File: rtl/dmac_channel_engine_if.sv
// Single-channel DMA bus beat interface: one request path shared by reads and writes.
// The engine drives m_valid/m_write/m_addr/m_wdata; the bus answers with m_ready/m_rdata.
// Backpressure: a beat is accepted only in a cycle where m_valid and m_ready are both 1.
//
// Ports (modport master = DMA engine, modport slave = bus / memory side):
//   m_valid  beat request         m_write  1 = write, 0 = read
//   m_addr   beat address         m_wdata  write data
//   m_ready  beat accepted        m_rdata  read data, valid in the accepting cycle
interface dmac_channel_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              m_valid;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_valid, m_write, m_addr, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/dmac_channel_engine.sv
// Purpose: one DMA channel moving xfer_size words src->dst as read bursts into a local FIFO,
//          each followed by a write burst that drains it.
// Latency: LOAD one cycle after start; one beat per cycle while m_ready=1; DONE pulse one
//          cycle after the final write beat.
// Backpressure: m_ready=0 freezes all bus outputs; nothing depends combinationally on m_ready.
//
// Ports: clk, rst (synchronous, active-high); start_i plus src/dst address, xfer/burst
//        size and fixed-address flags as configuration; m_if (master modport) carries the
//        bus beats; busy_o, done_o, fifo_level_o report status.
// Optional macro DMAC_CH_ABORT_EN adds abort_i / aborted_o (abort any active transfer).
module dmac_channel_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [ADDR_W-1:0]               src_addr_i,
    input  logic [ADDR_W-1:0]               dst_addr_i,
    input  logic [31:0]                     xfer_size_i,
    input  logic [31:0]                     burst_size_i,
    input  logic                            src_fixed_i,
    input  logic                            dst_fixed_i,
    dmac_channel_engine_if.master           m_if,
    output logic                            busy_o,
    output logic                            done_o,
`ifdef DMAC_CH_ABORT_EN
    input  logic                            abort_i,
    output logic                            aborted_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                LVL_W   = PTR_W + 1;
    localparam logic [31:0]       DEPTH32 = 32'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic              src_fix_q, src_fix_d, dst_fix_q, dst_fix_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [LVL_W-1:0]  eff_burst_q, eff_burst_d;
    logic [LVL_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LVL_W-1:0]  burst_len_q, burst_len_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push, pop, flush;
`ifdef DMAC_CH_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    // Burst of 0 is treated as single beats; anything deeper than the FIFO is cut to the
    // FIFO depth so a read burst can never overflow it.
    function automatic logic [LVL_W-1:0] clamp_burst(input logic [31:0] b);
        if (b == 32'd0)        return LVL_W'(1);
        else if (b > DEPTH32)  return LVL_W'(FIFO_DEPTH);
        else                   return b[LVL_W-1:0];
    endfunction

    // Final burst is shortened to whatever is left rather than split into single beats.
    function automatic logic [LVL_W-1:0] next_burst(input logic [LVL_W-1:0] eff,
                                                    input logic [31:0] rem);
        if (rem < 32'(eff)) return rem[LVL_W-1:0];
        else                return eff;
    endfunction

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        src_fix_d   = src_fix_q;
        dst_fix_d   = dst_fix_q;
        remaining_d = remaining_q;
        eff_burst_d = eff_burst_q;
        beat_cnt_d  = beat_cnt_q;
        burst_len_d = burst_len_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
`ifdef DMAC_CH_ABORT_EN
        aborted_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                src_d       = src_addr_i;
                dst_d       = dst_addr_i;
                src_fix_d   = src_fixed_i;
                dst_fix_d   = dst_fixed_i;
                remaining_d = xfer_size_i;
                eff_burst_d = clamp_burst(burst_size_i);
                if (xfer_size_i == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d     = S_READ;
                    beat_cnt_d  = next_burst(clamp_burst(burst_size_i), xfer_size_i);
                    burst_len_d = next_burst(clamp_burst(burst_size_i), xfer_size_i);
                end
            end
            S_READ: begin
                if (m_if.m_ready) begin
                    push       = 1'b1;
                    beat_cnt_d = beat_cnt_q - LVL_W'(1);
                    if (!src_fix_q) src_d = src_q + INC;
                    if (beat_cnt_q == LVL_W'(1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (m_if.m_ready) begin
                    pop = 1'b1;
                    if (!dst_fix_q) dst_d = dst_q + INC;
                    // Last word leaving the FIFO closes the burst.
                    if (level_q == LVL_W'(1)) begin
                        remaining_d = remaining_q - 32'(burst_len_q);
                        if (remaining_d == 32'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_READ;
                            beat_cnt_d  = next_burst(eff_burst_q, remaining_d);
                            burst_len_d = next_burst(eff_burst_q, remaining_d);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DMAC_CH_ABORT_EN
        // Abort wins over a beat accepted in the same cycle: nothing is pushed or popped.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            push      = 1'b0;
            pop       = 1'b0;
            flush     = 1'b1;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            src_fix_q   <= 1'b0;
            dst_fix_q   <= 1'b0;
            remaining_q <= '0;
            eff_burst_q <= '0;
            beat_cnt_q  <= '0;
            burst_len_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
`ifdef DMAC_CH_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            src_fix_q   <= src_fix_d;
            dst_fix_q   <= dst_fix_d;
            remaining_q <= remaining_d;
            eff_burst_q <= eff_burst_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_len_q <= burst_len_d;
`ifdef DMAC_CH_ABORT_EN
            aborted_q   <= aborted_d;
`endif
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                // Reads and writes are in separate states, so push and pop never coincide.
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    level_q  <= level_q + LVL_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    level_q  <= level_q - LVL_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: the level counter defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr_q] <= m_if.m_rdata;
    end

    // All outputs decode from registered state only.
    assign m_if.m_valid = (state_q == S_READ) || (state_q == S_WRITE);
    assign m_if.m_write = (state_q == S_WRITE);
    assign m_if.m_addr  = (state_q == S_READ)  ? src_q :
                          (state_q == S_WRITE) ? dst_q : '0;
    assign m_if.m_wdata = (state_q == S_WRITE) ? mem[rd_ptr_q] : '0;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign fifo_level_o = level_q;
`ifdef DMAC_CH_ABORT_EN
    assign aborted_o    = aborted_q;
`endif
endmodule

// File: tb/tb_dmac_channel_engine.sv
// Bench for dmac_channel_engine: acts as a randomly stalling bus slave and compares every
// accepted beat against a burst-level transfer model.
module tb_dmac_channel_engine;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src, dst, xfer, burst;
    logic        sfix, dfix;
    logic        busy, done;
    logic [$clog2(DEPTH):0] level;
`ifdef DMAC_CH_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    dmac_channel_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmac_channel_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .src_addr_i   (src),
        .dst_addr_i   (dst),
        .xfer_size_i  (xfer),
        .burst_size_i (burst),
        .src_fixed_i  (sfix),
        .dst_fixed_i  (dfix),
        .m_if         (bus.master),
        .busy_o       (busy),
        .done_o       (done),
`ifdef DMAC_CH_ABORT_EN
        .abort_i      (abort),
        .aborted_o    (aborted),
`endif
        .fifo_level_o (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one transfer and plays bus slave until the channel goes idle. The expected
    // beat list comes from the burst rules alone; write data must equal read data in order.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] x,
                            input logic [31:0] b, input logic sf, input logic df,
                            input int rdy_pct);
        logic [32:0] exp_q[$];
        logic [31:0] data_q[$];
        logic [31:0] sa, da, rem, eff, n, exp_data;
        logic [65:0] prev_out;
        logic        prev_stall;
        int          cycles, busy_cnt, done_cnt, peak;

        eff = (b == 0) ? 32'd1 : ((b > DEPTH) ? 32'(DEPTH) : b);
        rem = x; sa = s; da = d;
        while (rem > 0) begin
            n = (rem < eff) ? rem : eff;
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({1'b0, sa});
                if (!sf) sa = sa + 32'd4;
            end
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({1'b1, da});
                if (!df) da = da + 32'd4;
            end
            rem = rem - n;
        end

        src = s; dst = d; xfer = x; burst = b; sfix = sf; dfix = df;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0; busy_cnt = 0; done_cnt = 0; peak = 0;
        prev_stall = 1'b0; prev_out = '0;
        while (busy) begin
            busy_cnt++;
            if (done) done_cnt++;
            if (int'(level) > peak) peak = int'(level);
            if (prev_stall)
                check("stall_stable", {bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata}, prev_out);
            if (bus.m_valid) begin
                bus.m_ready = ($urandom_range(99) < rdy_pct);
                bus.m_rdata = $urandom;
                if (bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", {bus.m_write, bus.m_addr}, 33'd0);
                    end else begin
                        check("beat_kind_addr", {bus.m_write, bus.m_addr}, exp_q.pop_front());
                    end
                    if (!bus.m_write) begin
                        data_q.push_back(bus.m_rdata);
                    end else begin
                        exp_data = (data_q.size() > 0) ? data_q.pop_front() : 32'hDEAD_BEEF;
                        check("write_data", bus.m_wdata, exp_data);
                    end
                end
                prev_stall = !bus.m_ready;
                prev_out   = {bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata};
            end else begin
                bus.m_ready = 1'b0;
                prev_stall  = 1'b0;
            end
            cycles++;
            if (cycles > 5000) begin
                check("xfer_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("beats_left", exp_q.size(), 0);
        check("fifo_peak", peak, (x < eff) ? x : eff);
        check("idle_level", level, 0);
        if (x == 0) check("zero_busy_cycles", busy_cnt, 2);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0;
        src = '0; dst = '0; xfer = '0; burst = '0; sfix = 1'b0; dfix = 1'b0;
        bus.m_ready = 1'b0; bus.m_rdata = '0;
`ifdef DMAC_CH_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_bus", {bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata}, 66'd0);
        check("rst_status", {busy, done, level}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, bus.m_valid}, 2'b00);

        run_xfer(32'h100, 32'h200, 8, 4, 1'b0, 1'b0, 100);
        run_xfer(32'h1000, 32'h2000, 10, 4, 1'b0, 1'b0, 60);
        run_xfer(32'h300, 32'h400, 0, 4, 1'b0, 1'b0, 100);
        run_xfer(32'h500, 32'h600, 3, 0, 1'b0, 1'b0, 70);
        run_xfer(32'h4000, 32'h8000, 32, 64, 1'b0, 1'b0, 80);
        run_xfer(32'hFFFF_FFF8, 32'h700, 4, 4, 1'b0, 1'b1, 40);
        for (int t = 0; t < 6; t++)
            run_xfer($urandom, $urandom, 32'($urandom_range(40)), 32'($urandom_range(20)),
                     1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(100, 30)));

        // Reset while a write beat is being accepted.
        src = 32'h100; dst = 32'h200; xfer = 8; burst = 4; sfix = 1'b0; dfix = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.m_valid && bus.m_write) && cyc < 100) begin
            bus.m_ready = bus.m_valid;
            bus.m_rdata = $urandom;
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_write", cyc < 100, 1);
        bus.m_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_write", {busy, done, bus.m_valid, level}, 0);
`ifdef DMAC_CH_ABORT_EN
        check("rst_no_aborted", aborted, 0);
`endif
        rst = 1'b0; bus.m_ready = 1'b0;
        @(negedge clk);
        check("rst_stays_idle", {busy, done}, 2'b00);

`ifdef DMAC_CH_ABORT_EN
        // Abort two beats into a read burst, with a beat offered in the same cycle.
        src = 32'h100; dst = 32'h200; xfer = 8; burst = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.m_valid && !bus.m_write && level == 2) && cyc < 100) begin
            bus.m_ready = bus.m_valid;
            bus.m_rdata = $urandom;
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_read", cyc < 100, 1);
        bus.m_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_idle", {busy, done, bus.m_valid, level}, 0);
        check("aborted_pulse", aborted, 1);
        abort = 1'b0; bus.m_ready = 1'b0;
        @(negedge clk);
        check("aborted_one_cycle", {aborted, busy, done}, 3'b000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmac_channel_engine.md
DMAC_CHANNEL_ENGINE -- requirements
Module: dmac_channel_engine

Interface
REQ-001 Parameter DATA_W, default 32, bus data width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, bus address width in bits.
REQ-003 Parameter FIFO_DEPTH, default 16, buffer depth in words; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse launching a transfer from the configuration inputs.
REQ-007 src_addr / dst_addr  input  ADDR_W each  start addresses.
REQ-008 xfer_size  input  32  total words to move.
REQ-009 burst_size  input  32  beats per burst.
REQ-010 src_fixed / dst_fixed  input  1 each  1 = hold address, 0 = increment.
REQ-011 m_valid  output  1  bus beat request.
REQ-012 m_write  output  1  1 = write beat, 0 = read beat.
REQ-013 m_addr  output  ADDR_W  beat address.
REQ-014 m_wdata  output  DATA_W  write data, FIFO head.
REQ-015 m_ready  input  1  beat accepted this cycle when m_valid=1.
REQ-016 m_rdata  input  DATA_W  read data, valid in the accepting cycle.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 FSM states IDLE, LOAD, READ, WRITE, DONE; IDLE->LOAD on start; all other states ignore start.
REQ-021 LOAD (1 cycle): latch addresses, remaining=xfer_size, eff_burst=burst_size, with 0 mapped to 1 and values above FIFO_DEPTH clamped to FIFO_DEPTH; next state DONE if remaining=0, else READ.
REQ-022 On entering READ, beat_cnt=min(eff_burst, remaining); partial final bursts SHALL be issued as one shortened burst, not as single-word bursts.
REQ-023 READ: m_valid=1, m_write=0, m_addr=src pointer; each beat with m_ready=1 pushes m_rdata into the FIFO, decrements beat_cnt, and advances the source pointer unless src_fixed.
REQ-024 READ->WRITE in the cycle after the last beat of the burst is accepted.
REQ-025 WRITE: m_valid=1, m_write=1, m_addr=dst pointer, m_wdata=FIFO head; each accepted beat pops the FIFO and advances the destination pointer unless dst_fixed.
REQ-026 WRITE exits when the FIFO empties: remaining-=burst length; next state DONE if remaining=0, else READ.
REQ-027 Pointer increment=DATA_W/8; address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-028 When m_ready=0, m_valid, m_addr, m_write and m_wdata SHALL hold stable.
REQ-029 A FIFO push when full or a pop when empty SHALL never occur; the burst clamp guarantees this.
REQ-030 DONE lasts one cycle with done=1, then returns to IDLE; outputs are registered or state-decoded with zero combinational path from m_ready.
REQ-031 m_valid=0 and m_wdata=0 in IDLE, LOAD and DONE.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, FIFO empty, and all pointers and counters to 0, overriding any in-flight beat.
REQ-033 Outputs after reset: m_valid=0, m_write=0, m_addr=0, m_wdata=0, busy=0, done=0, fifo_level=0.

Configuration
REQ-034 Macro DMAC_CH_ABORT_EN: when defined, adds input abort (1 bit) and output aborted (1 bit).
REQ-035 With DMAC_CH_ABORT_EN defined: abort=1 in any non-IDLE state -> IDLE next cycle, FIFO flushed, aborted pulses 1 cycle, and done stays 0; abort in IDLE is ignored; abort has priority over m_ready in the same cycle.
REQ-036 Without DMAC_CH_ABORT_EN: neither port exists, and transfers always run to DONE.

Verification
REQ-037 src=0x100, dst=0x200, xfer=8, burst=4, both incrementing -> two bursts of 4 reads then 4 writes; read addresses 0x100..0x11C; done pulses once; destination receives data in order.
REQ-038 xfer=10, burst=4 -> burst lengths 4, 4, 2; exactly 10 write beats.
REQ-039 xfer=0 -> busy for 2 cycles (LOAD, DONE), done=1, zero bus beats; burst=0, xfer=3 -> three 1-beat bursts.
REQ-040 burst=64, FIFO_DEPTH=16, xfer=32 -> two 16-beat bursts, fifo_level peaks at 16 and never exceeds it.
REQ-041 dst_fixed=1, src=0xFFFFFFF8, xfer=4, random m_ready stalls -> source addresses wrap to 0x0 and 0x4; all write beats target dst; stalled outputs stay stable.
REQ-042 rst asserted mid-WRITE, and (with DMAC_CH_ABORT_EN) abort mid-READ -> IDLE next cycle, fifo_level=0, done=0; aborted=1 for the abort case only.
